// File: rtl/decoder_n_sync_pkg.sv
// Shared definitions for the registered one-hot select decoder:
// FSM encodings, mode constants and the strobe counter width.
package decoder_n_sync_pkg;

  localparam int DEC_CNT_W = 8;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    STROBE = 1'b1
  } state_t;

endpackage

// File: rtl/decoder_n.sv
// Purely combinational W-to-2^W one-hot core, the generalised form of the
// old fixed 3-to-8 decoder.
module decoder_n #(
  parameter int W = 3
) (
  input  logic [W-1:0]      sel,
  output logic [(2**W)-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_n_sync.sv
// Registered one-hot select decoder with valid/ready intake, per-output mask
// and level/pulse output modes; pulse strobes last HOLD cycles.
module decoder_n_sync
  import decoder_n_sync_pkg::*;
#(
  parameter int W    = 3,
  parameter int HOLD = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        sel,
  input  logic                mode,
  input  logic [(2**W)-1:0]   mask,
  output logic [(2**W)-1:0]   out,
  output logic                busy,
  output logic                miss
);

  localparam int N = 2**W;
  localparam logic [DEC_CNT_W-1:0] CNT_LOAD = DEC_CNT_W'(HOLD - 1);

  if (HOLD < 1 || HOLD > 255) begin : g_hold_check
    $error("decoder_n_sync: HOLD must be in the range 1..255");
  end

  state_t               state;
  state_t               state_nxt;
  logic [DEC_CNT_W-1:0] cnt;
  logic                 short_pulse;
  logic [N-1:0]         onehot;
  logic [N-1:0]         masked;
  logic                 accept;

  decoder_n #(.W(W)) u_core (
    .sel    (sel),
    .onehot (onehot)
  );

  assign masked = onehot & mask;
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A single-cycle strobe never leaves IDLE, so back-to-back accepts work.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && mode == MODE_PULSE && HOLD > 1) begin
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state == STROBE) | short_pulse;
  end

  // Every accept replaces out wholesale; a masked index yields all-zero plus miss.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out         <= '0;
      cnt         <= '0;
      short_pulse <= 1'b0;
      miss        <= 1'b0;
    end else begin
      miss        <= 1'b0;
      short_pulse <= 1'b0;
      if (accept) begin
        out  <= masked;
        miss <= (masked == '0);
        if (mode != MODE_LEVEL) begin
          cnt         <= CNT_LOAD;
          short_pulse <= (HOLD == 1);
        end
      end else if (state == STROBE) begin
        if (cnt == '0) begin
          out <= '0;
        end else begin
          cnt <= cnt - DEC_CNT_W'(1);
        end
      end else if (short_pulse) begin
        out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_decoder_n_sync.sv
// Self-checking bench: three decoder instances (HOLD=3, HOLD=1, W=5/HOLD=4)
// compared every cycle against a behavioural strobe model, plus directed cases.
module tb_decoder_n_sync;

  logic        clk;
  logic        reset_n;
  logic [2:0]  v;
  logic [4:0]  sel_s  [3];
  logic [2:0]  mode_v;
  logic [31:0] mask_s [3];
  logic [2:0]  rdy;
  logic [2:0]  bsy;
  logic [2:0]  mss;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic [31:0] out_c;
  logic [31:0] dut_out [3];

  int checks = 0;
  int errors = 0;

  int hold_of [3] = '{3, 1, 4};
  int w_of    [3] = '{3, 3, 5};

  logic [31:0] m_out    [3];
  bit          m_active [3];
  bit          m_miss   [3];
  bit          m_acc    [3];
  int          m_left   [3];

  decoder_n_sync #(.W(3), .HOLD(3)) dut_h3 (
    .clk(clk), .reset_n(reset_n), .in_valid(v[0]), .in_ready(rdy[0]),
    .sel(sel_s[0][2:0]), .mode(mode_v[0]), .mask(mask_s[0][7:0]),
    .out(out_a), .busy(bsy[0]), .miss(mss[0])
  );

  decoder_n_sync #(.W(3), .HOLD(1)) dut_h1 (
    .clk(clk), .reset_n(reset_n), .in_valid(v[1]), .in_ready(rdy[1]),
    .sel(sel_s[1][2:0]), .mode(mode_v[1]), .mask(mask_s[1][7:0]),
    .out(out_b), .busy(bsy[1]), .miss(mss[1])
  );

  decoder_n_sync #(.W(5), .HOLD(4)) dut_w5 (
    .clk(clk), .reset_n(reset_n), .in_valid(v[2]), .in_ready(rdy[2]),
    .sel(sel_s[2]), .mode(mode_v[2]), .mask(mask_s[2]),
    .out(out_c), .busy(bsy[2]), .miss(mss[2])
  );

  assign dut_out[0] = {24'h0, out_a};
  assign dut_out[1] = {24'h0, out_b};
  assign dut_out[2] = out_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input bit valid, input int s, input bit md,
                               input logic [31:0] msk);
    v[i]      = valid;
    sel_s[i]  = 5'(s);
    mode_v[i] = md;
    mask_s[i] = msk;
  endtask

  function automatic bit modelReady(input int i);
    return !m_active[i] || hold_of[i] == 1;
  endfunction

  // Strobe model: an accepted pulse stays visible for HOLD cycles, then clears.
  task automatic modelStep(input int i);
    int idx;
    if (!reset_n) begin
      m_out[i] = '0; m_active[i] = 0; m_miss[i] = 0; m_left[i] = 0; m_acc[i] = 0;
    end else begin
      m_acc[i]  = v[i] && modelReady(i);
      m_miss[i] = 0;
      if (m_acc[i]) begin
        idx       = int'(sel_s[i]) % (1 << w_of[i]);
        m_out[i]  = mask_s[i][idx] ? (32'd1 << idx) : 32'd0;
        m_miss[i] = !mask_s[i][idx];
        m_active[i] = mode_v[i];
        m_left[i]   = hold_of[i] - 1;
      end else if (m_active[i]) begin
        if (m_left[i] == 0) begin
          m_active[i] = 0;
          m_out[i]    = '0;
        end else begin
          m_left[i]--;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) modelStep(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("d%0d.out", i),    dut_out[i], m_out[i]);
      checkOutput($sformatf("d%0d.busy", i),   32'(bsy[i]), 32'(m_active[i]));
      checkOutput($sformatf("d%0d.miss", i),   32'(mss[i]), 32'(m_miss[i]));
      checkOutput($sformatf("d%0d.ready", i),  32'(rdy[i]), 32'(modelReady(i)));
      checkOutput($sformatf("d%0d.onehot", i), 32'($countones(dut_out[i]) <= 1), 32'd1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(i, 0, 0, 0, 32'hFFFF_FFFF);
    tick();
    tick();
    checkOutput("reset.out_c", out_c, 32'd0);
    reset_n = 1'b1;
    tick();
    checkOutput("reset.ready", 32'(rdy), 32'h7);

    // Level mode holds until the next accept.
    applyStimulus(0, 1, 2, 0, 32'hFF);
    tick();
    applyStimulus(0, 0, 2, 0, 32'hFF);
    checkOutput("lvl.sel2", 32'(out_a), 32'h04);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("lvl.hold", 32'(out_a), 32'h04);
    end
    applyStimulus(0, 1, 7, 0, 32'hFF);
    tick();
    applyStimulus(0, 0, 7, 0, 32'hFF);
    checkOutput("lvl.sel7", 32'(out_a), 32'h80);

    // HOLD=3 pulse, with a follow-up request held through the strobe.
    applyStimulus(0, 1, 5, 1, 32'hFF);
    tick();
    checkOutput("p3.c1.out", 32'(out_a), 32'h20);
    applyStimulus(0, 1, 1, 0, 32'hFF);
    tick();
    checkOutput("p3.c2.out", 32'(out_a), 32'h20);
    checkOutput("p3.c2.busy", 32'(bsy[0]), 32'd1);
    checkOutput("p3.c2.ready", 32'(rdy[0]), 32'd0);
    tick();
    checkOutput("p3.c3.out", 32'(out_a), 32'h20);
    tick();
    checkOutput("p3.end.out", 32'(out_a), 32'h00);
    checkOutput("p3.end.busy", 32'(bsy[0]), 32'd0);
    checkOutput("p3.end.ready", 32'(rdy[0]), 32'd1);
    tick();
    applyStimulus(0, 0, 1, 0, 32'hFF);
    checkOutput("p3.held.out", 32'(out_a), 32'h02);

    // HOLD=1 back-to-back strobes.
    for (int s = 1; s <= 3; s++) begin
      applyStimulus(1, 1, s, 1, 32'hFF);
      tick();
      checkOutput($sformatf("p1.sel%0d", s), 32'(out_b), 32'd1 << s);
    end
    applyStimulus(1, 0, 0, 0, 32'hFF);
    tick();
    checkOutput("p1.clear", 32'(out_b), 32'd0);

    // Masked index, level then pulse.
    applyStimulus(0, 1, 4, 0, 32'hEF);
    tick();
    applyStimulus(0, 0, 4, 0, 32'hEF);
    checkOutput("mask.lvl.out", 32'(out_a), 32'd0);
    checkOutput("mask.lvl.miss", 32'(mss[0]), 32'd1);
    tick();
    checkOutput("mask.lvl.miss2", 32'(mss[0]), 32'd0);
    applyStimulus(0, 1, 4, 1, 32'hEF);
    tick();
    applyStimulus(0, 0, 4, 1, 32'hEF);
    checkOutput("mask.p.miss", 32'(mss[0]), 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("mask.p.busy", 32'(bsy[0]), 32'd1);
    end
    tick();
    checkOutput("mask.p.done", 32'(bsy[0]), 32'd0);

    // Reset on the second cycle of a HOLD=4 strobe; request during reset is dropped.
    applyStimulus(2, 1, 3, 1, 32'hFFFF_FFFF);
    tick();
    applyStimulus(2, 0, 3, 1, 32'hFFFF_FFFF);
    tick();
    checkOutput("rst.pre.busy", 32'(bsy[2]), 32'd1);
    reset_n = 1'b0;
    applyStimulus(2, 1, 9, 0, 32'hFFFF_FFFF);
    tick();
    checkOutput("rst.out", out_c, 32'd0);
    checkOutput("rst.busy", 32'(bsy[2]), 32'd0);
    checkOutput("rst.ready", 32'(rdy[2]), 32'd1);
    reset_n = 1'b1;
    applyStimulus(2, 0, 9, 0, 32'hFFFF_FFFF);
    tick();
    checkOutput("rst.dropped", out_c, 32'd0);
    applyStimulus(2, 1, 0, 0, 32'hFFFF_FFFF);
    tick();
    checkOutput("rst.sel0", out_c, 32'd1);

    // W=5 level sweep.
    for (int s = 0; s < 32; s++) begin
      applyStimulus(2, 1, s, 0, 32'hFFFF_FFFF);
      tick();
      checkOutput($sformatf("w5.sel%0d", s), out_c, 32'd1 << s);
    end
    applyStimulus(2, 0, 0, 0, 32'hFFFF_FFFF);

    // Random traffic; an unaccepted request is held unchanged.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v[i] || m_acc[i]) begin
          applyStimulus(i, 1'($urandom_range(1, 0)),
                        int'($urandom_range((1 << w_of[i]) - 1, 0)),
                        1'($urandom_range(1, 0)),
                        ($urandom_range(3, 0) == 0) ? $urandom : 32'hFFFF_FFFF);
        end
      end
      reset_n = ($urandom_range(59, 0) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
